// File: rtl/proc_n_pkg.sv
// rtl/proc_n_pkg.sv - shared opcode, state and width definitions for proc_n
package proc_n_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_MVNZ = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

endpackage

// File: rtl/proc_n_if.sv
// rtl/proc_n_if.sv - Run/Done handshake, instruction input and bus/flag outputs
interface proc_n_if #(parameter int DW = 16) ();

  logic [DW-1:0] DIN;
  logic          Run;
  logic          Done;
  logic [DW-1:0] BusWires;
  logic          Zflag;
  logic          Cflag;

  modport master (output DIN, Run, input Done, BusWires, Zflag, Cflag);
  modport slave  (input DIN, Run, output Done, BusWires, Zflag, Cflag);

endinterface

// File: rtl/alu_n.sv
// rtl/alu_n.sv - combinational ALU: add/sub with carry-borrow, and/or/xor with C cleared
module alu_n
  import proc_n_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  opcode_t       op,
  output logic [DW-1:0] result,
  output logic          z,
  output logic          c
);

  logic [DW:0] sum;
  logic [DW:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  // Bit DW of the widened difference is set exactly when a < b (borrow).
  assign dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    c      = 1'b0;
    case (op)
      OP_ADD:  {c, result} = sum;
      OP_SUB:  {c, result} = dif;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/regn.sv
// rtl/regn.sv - DW-bit load-enabled register with asynchronous clear
module regn #(
  parameter int DW = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          rin,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q <= '0;
    end else if (rin) begin
      q <= d;
    end
  end

endmodule

// File: rtl/proc_n.sv
// rtl/proc_n.sv - multi-cycle shared-bus processor core with parametrised width and register count
module proc_n
  import proc_n_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic     Clock,
  input  logic     Resetn,
  proc_n_if.slave  cpu
);

  localparam int RW = $clog2(NREG);

  localparam logic [1:0] ST_T0 = 2'(T0);
  localparam logic [1:0] ST_T1 = 2'(T1);
  localparam logic [1:0] ST_T2 = 2'(T2);
  localparam logic [1:0] ST_T3 = 2'(T3);

  if (DW < OPW + 2 * RW) begin : g_bad_dw
    $error("proc_n: DW must be at least 3 + 2*RW");
  end
  if (NREG < 2 || NREG > 16 || (1 << RW) != NREG) begin : g_bad_nreg
    $error("proc_n: NREG must be a power of two in 2..16");
  end

  logic [1:0]    state, state_nxt;
  logic [DW-1:0] ir, a, g, bus;
  logic [DW-1:0] r [NREG];
  logic [NREG-1:0] rin, rsel;
  logic          ain, gin, gsel, dsel, done;
  logic          zflag, cflag;
  logic [DW-1:0] alu_res;
  logic          alu_z, alu_c;
  opcode_t       op;
  logic [RW-1:0] rx, ry;
  logic          unused_ir;

  assign op        = opcode_t'(ir[DW-1 -: OPW]);
  assign rx        = ir[DW-OPW-1 -: RW];
  assign ry        = ir[DW-OPW-1-RW -: RW];
  assign unused_ir = ^ir;

  always_comb begin
    state_nxt = state;
    rin       = '0;
    rsel      = '0;
    ain       = 1'b0;
    gin       = 1'b0;
    gsel      = 1'b0;
    dsel      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_T0: if (cpu.Run) state_nxt = ST_T1;
      ST_T1: begin
        case (op)
          OP_MV, OP_MVNZ: begin
            rsel[ry]  = 1'b1;
            rin[rx]   = (op == OP_MV) | !zflag;
            done      = 1'b1;
            state_nxt = ST_T0;
          end
          OP_MVI: begin
            dsel      = 1'b1;
            rin[rx]   = 1'b1;
            done      = 1'b1;
            state_nxt = ST_T0;
          end
          default: begin
            rsel[rx]  = 1'b1;
            ain       = 1'b1;
            state_nxt = ST_T2;
          end
        endcase
      end
      ST_T2: begin
        rsel[ry]  = 1'b1;
        gin       = 1'b1;
        state_nxt = ST_T3;
      end
      default: begin
        gsel      = 1'b1;
        rin[rx]   = 1'b1;
        done      = 1'b1;
        state_nxt = ST_T0;
      end
    endcase
  end

  // One-hot AND-OR bus; an idle bus falls back to DIN.
  always_comb begin
    bus = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rsel[i]) bus |= r[i];
    end
    if (gsel) bus |= g;
    if (dsel || !(|rsel || gsel)) bus |= cpu.DIN;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= ST_T0;
      ir    <= '0;
      a     <= '0;
      g     <= '0;
      zflag <= 1'b0;
      cflag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_T0 && cpu.Run) ir <= cpu.DIN;
      if (ain) a <= bus;
      if (gin) begin
        g     <= alu_res;
        zflag <= alu_z;
        cflag <= alu_c;
      end
    end
  end

  alu_n #(.DW(DW)) u_alu (
    .a      (a),
    .b      (bus),
    .op     (op),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c)
  );

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    regn #(.DW(DW)) u_r (
      .Clock  (Clock),
      .Resetn (Resetn),
      .rin    (rin[gi]),
      .d      (bus),
      .q      (r[gi])
    );
  end

  assign cpu.Done     = done;
  assign cpu.BusWires = bus;
  assign cpu.Zflag    = zflag;
  assign cpu.Cflag    = cflag;

endmodule
